sys_ctrl: RTL
=============

# sys_ctrl

Command-sequencing controller between the UART receive path and the register file, ALU and TX FIFO. It decodes byte frames from UART RX, issues register-file writes/reads and ALU operations, and queues result bytes toward UART TX through the TX FIFO. It runs entirely in the reference (REF) clock domain; RX data enters already synchronized as a byte plus a one-cycle valid pulse.

## Interface
- DATA_WID, 8, byte width of RX/TX/regfile data
- ADDR_WID, 4, register-file address width
- FUN_WID, 4, ALU function code width
- ALU_OUT_WID, 16, ALU result width (= 2*DATA_WID)

- CLK  in  1  controller clock (REF domain)
- RST  in  1  synchronous, active-low reset
- RX_P_DATA  in  DATA_WID  received byte
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
- RD_DATA  in  DATA_WID  register-file read data
- RD_DATA_VALID  in  1  RD_DATA valid pulse
- ALU_OUT  in  ALU_OUT_WID  ALU result
- ALU_OUT_VALID  in  1  ALU result valid pulse
- FIFO_FULL  in  1  TX FIFO full
- WR_EN, RD_EN  out  1  register-file write/read strobes
- ADDRESS  out  ADDR_WID  register-file address
- WR_DATA  out  DATA_WID  register-file write data
- ALU_EN  out  1  ALU start strobe
- ALU_FUN  out  FUN_WID  ALU function
- CLK_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  DATA_WID  byte to TX FIFO
- TX_D_VLD  out  1  TX FIFO write strobe

## Operation
- Frames (first byte = opcode): 0xAA addr data (write); 0xBB addr (read); 0xCC A B fun (ALU with operands); 0xDD fun (ALU, no operands).
- Addresses use byte[ADDR_WID-1:0]; fun uses byte[FUN_WID-1:0].
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_BYTE.
- IDLE: on RX_D_VLD, opcode AA->WR_ADDR, BB->RD_ADDR, CC->ALU_A, DD->ALU_FUN; any other byte discarded, stay IDLE.
- WR_ADDR: latch address -> WR_DATA. WR_DATA: on byte, one WR_EN pulse with ADDRESS/WR_DATA -> IDLE.
- RD_ADDR: on byte, one RD_EN pulse -> RD_WAIT; on RD_DATA_VALID latch RD_DATA, queue 1 byte -> TX_BYTE.
- ALU_A / ALU_B: on byte, WR_EN pulse to address 0 / 1 respectively -> ALU_B / ALU_FUN.
- ALU_FUN: on byte, CLK_EN rises, ALU_EN pulses one cycle with ALU_FUN -> ALU_WAIT; on ALU_OUT_VALID latch result, CLK_EN falls, queue 2 bytes (low then high) -> TX_BYTE.
- TX_BYTE: present queued byte; TX_D_VLD asserted only while FIFO_FULL=0; each asserted cycle = one FIFO write; after last byte -> IDLE.
- RX_D_VLD outside a byte-accepting state (RD_WAIT, ALU_WAIT, TX_BYTE) is dropped.
- No timeout: RD_WAIT/ALU_WAIT hold until the valid pulse.

## Timing
- All outputs registered. Reset (RST=0 at a CLK edge): state IDLE; WR_EN, RD_EN, ALU_EN, CLK_EN, TX_D_VLD = 0; ADDRESS, WR_DATA, ALU_FUN, TX_P_DATA = 0.
- Strobes (WR_EN, RD_EN, ALU_EN) high exactly one cycle, in the cycle after the RX_D_VLD that completes them; ADDRESS/WR_DATA/ALU_FUN valid in that same cycle and held until next command.
- CLK_EN high from the ALU_EN cycle through the cycle ALU_OUT_VALID is sampled; low the cycle after.
- First TX_D_VLD no earlier than the cycle after the latching valid pulse; ALU bytes on consecutive cycles if FIFO_FULL=0.
- FIFO_FULL rising mid-sequence: TX_D_VLD drops the same cycle (combinational gate with registered byte); byte held; resumes with no loss or duplication.
- Reset mid-frame or mid-TX: abandons frame, pending bytes discarded.

## Structure
- Package sys_ctrl_pkg: opcode constants (0xAA/0xBB/0xCC/0xDD), state enum, ALU operand addresses (0, 1).
- One sub-module sys_ctrl_tx_q: 2-byte hold buffer + FIFO_FULL handshake, load/count in, TX_P_DATA/TX_D_VLD/done out.

## Test plan
- AA,05,3C -> one WR_EN pulse, ADDRESS=5, WR_DATA=0x3C; no TX_D_VLD.
- BB,02 then RD_DATA=0x7E valid -> RD_EN pulse ADDRESS=2; one TX_D_VLD with TX_P_DATA=0x7E.
- CC,10,20,00 then ALU_OUT=0x0030 -> WR_EN addr0=0x10, addr1=0x20, ALU_EN with FUN=0, CLK_EN window correct; TX bytes 0x30 then 0x00.
- DD,02 with FIFO_FULL=1 for 5 cycles after ALU_OUT=0x1234 -> no TX_D_VLD while full; then 0x34, 0x12, each exactly once.
- 0x55 then AA,01,FF -> 0x55 ignored; write addr1=0xFF succeeds.
- Reset asserted after CC,10 -> all outputs at reset values; subsequent BB,00 frame handled normally.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared widths, opcodes, state encoding and ALU operand addresses for sys_ctrl.
package sys_ctrl_pkg;

  localparam int unsigned DATA_WID    = 8;
  localparam int unsigned ADDR_WID    = 4;
  localparam int unsigned FUN_WID     = 4;
  localparam int unsigned ALU_OUT_WID = 2 * DATA_WID;
  localparam int unsigned ST_WID      = 4;

  // Frame opcodes (first byte of every frame)
  localparam logic [DATA_WID-1:0] OP_WRITE   = 8'hAA;
  localparam logic [DATA_WID-1:0] OP_READ    = 8'hBB;
  localparam logic [DATA_WID-1:0] OP_ALU_OPS = 8'hCC;
  localparam logic [DATA_WID-1:0] OP_ALU_NOP = 8'hDD;

  // Controller state encoding
  typedef logic [ST_WID-1:0] state_t;
  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_WR_ADDR  = 4'd1;
  localparam state_t ST_WR_DATA  = 4'd2;
  localparam state_t ST_RD_ADDR  = 4'd3;
  localparam state_t ST_RD_WAIT  = 4'd4;
  localparam state_t ST_ALU_A    = 4'd5;
  localparam state_t ST_ALU_B    = 4'd6;
  localparam state_t ST_ALU_FUN  = 4'd7;
  localparam state_t ST_ALU_WAIT = 4'd8;
  localparam state_t ST_TX_BYTE  = 4'd9;

  // Register-file slots that hold the ALU operands
  localparam logic [ADDR_WID-1:0] ALU_A_ADDR = 4'd0;
  localparam logic [ADDR_WID-1:0] ALU_B_ADDR = 4'd1;

endpackage

// File: rtl/sys_ctrl_tx_q.sv
// Two-byte hold buffer that drains low byte first into the TX FIFO, stalling on full.
module sys_ctrl_tx_q
  import sys_ctrl_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic [ALU_OUT_WID-1:0] i_data,
  input  logic                   i_two,
  input  logic                   i_fifo_full,
  output logic [DATA_WID-1:0]    o_tx_p_data,
  output logic                   o_tx_d_vld_c,
  output logic                   o_done_c
);

  logic [ALU_OUT_WID-1:0] r_buf;
  logic [1:0]             r_left;
  logic                   w_vld;

  // A byte is written in every cycle it is pending and the FIFO has room
  assign w_vld        = (r_left != 2'd0) && !i_fifo_full;
  assign o_tx_d_vld_c = w_vld;
  assign o_done_c     = w_vld && (r_left == 2'd1);
  assign o_tx_p_data  = r_buf[DATA_WID-1:0];

  // Load a fresh result, or shift out the byte just accepted by the FIFO
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_buf  <= '0;
      r_left <= 2'd0;
    end else if (i_load) begin
      r_buf  <= i_data;
      r_left <= i_two ? 2'd2 : 2'd1;
    end else if (w_vld) begin
      r_buf  <= {DATA_WID'(0), r_buf[ALU_OUT_WID-1:DATA_WID]};
      r_left <= r_left - 2'd1;
    end
  end

endmodule

// File: rtl/sys_ctrl.sv
// Frame decoder driving register file, ALU and TX FIFO from received UART bytes.
module sys_ctrl
  import sys_ctrl_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WID-1:0]    RX_P_DATA,
  input  logic                   RX_D_VLD,
  input  logic [DATA_WID-1:0]    RD_DATA,
  input  logic                   RD_DATA_VALID,
  input  logic [ALU_OUT_WID-1:0] ALU_OUT,
  input  logic                   ALU_OUT_VALID,
  input  logic                   FIFO_FULL,
  output logic                   WR_EN,
  output logic                   RD_EN,
  output logic [ADDR_WID-1:0]    ADDRESS,
  output logic [DATA_WID-1:0]    WR_DATA,
  output logic                   ALU_EN,
  output logic [FUN_WID-1:0]     ALU_FUN,
  output logic                   CLK_EN,
  output logic [DATA_WID-1:0]    TX_P_DATA,
  output logic                   TX_D_VLD
);

  state_t                 r_state, w_state_nxt;
  logic [ADDR_WID-1:0]    r_wr_addr, w_wr_addr_nxt;
  logic                   r_wr_en, w_wr_en_nxt;
  logic                   r_rd_en, w_rd_en_nxt;
  logic                   r_alu_en, w_alu_en_nxt;
  logic                   r_clk_en, w_clk_en_nxt;
  logic [ADDR_WID-1:0]    r_address, w_address_nxt;
  logic [DATA_WID-1:0]    r_wr_data, w_wr_data_nxt;
  logic [FUN_WID-1:0]     r_alu_fun, w_alu_fun_nxt;
  logic                   w_q_load, w_q_two, w_q_done;
  logic [ALU_OUT_WID-1:0] w_q_data;

  assign WR_EN   = r_wr_en;
  assign RD_EN   = r_rd_en;
  assign ADDRESS = r_address;
  assign WR_DATA = r_wr_data;
  assign ALU_EN  = r_alu_en;
  assign ALU_FUN = r_alu_fun;
  assign CLK_EN  = r_clk_en;

  // Next state and next registered outputs; strobes default low, data fields hold
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_en_nxt   = 1'b0;
    w_rd_en_nxt   = 1'b0;
    w_alu_en_nxt  = 1'b0;
    w_clk_en_nxt  = r_clk_en;
    w_address_nxt = r_address;
    w_wr_data_nxt = r_wr_data;
    w_alu_fun_nxt = r_alu_fun;
    w_q_load      = 1'b0;
    w_q_two       = 1'b0;
    w_q_data      = '0;
    case (r_state)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            OP_WRITE:   w_state_nxt = ST_WR_ADDR;
            OP_READ:    w_state_nxt = ST_RD_ADDR;
            OP_ALU_OPS: w_state_nxt = ST_ALU_A;
            OP_ALU_NOP: w_state_nxt = ST_ALU_FUN;
            default:    w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          w_wr_addr_nxt = RX_P_DATA[ADDR_WID-1:0];
          w_state_nxt   = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          w_wr_en_nxt   = 1'b1;
          w_address_nxt = r_wr_addr;
          w_wr_data_nxt = RX_P_DATA;
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          w_rd_en_nxt   = 1'b1;
          w_address_nxt = RX_P_DATA[ADDR_WID-1:0];
          w_state_nxt   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (RD_DATA_VALID) begin
          w_q_load    = 1'b1;
          w_q_data    = {DATA_WID'(0), RD_DATA};
          w_state_nxt = ST_TX_BYTE;
        end
      end
      ST_ALU_A: begin
        if (RX_D_VLD) begin
          w_wr_en_nxt   = 1'b1;
          w_address_nxt = ALU_A_ADDR;
          w_wr_data_nxt = RX_P_DATA;
          w_state_nxt   = ST_ALU_B;
        end
      end
      ST_ALU_B: begin
        if (RX_D_VLD) begin
          w_wr_en_nxt   = 1'b1;
          w_address_nxt = ALU_B_ADDR;
          w_wr_data_nxt = RX_P_DATA;
          w_state_nxt   = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        if (RX_D_VLD) begin
          w_alu_en_nxt  = 1'b1;
          w_clk_en_nxt  = 1'b1;
          w_alu_fun_nxt = RX_P_DATA[FUN_WID-1:0];
          w_state_nxt   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (ALU_OUT_VALID) begin
          w_clk_en_nxt = 1'b0;
          w_q_load     = 1'b1;
          w_q_two      = 1'b1;
          w_q_data     = ALU_OUT;
          w_state_nxt  = ST_TX_BYTE;
        end
      end
      ST_TX_BYTE: begin
        if (w_q_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_wr_addr <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_clk_en  <= 1'b0;
      r_address <= '0;
      r_wr_data <= '0;
      r_alu_fun <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_alu_en  <= w_alu_en_nxt;
      r_clk_en  <= w_clk_en_nxt;
      r_address <= w_address_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_alu_fun <= w_alu_fun_nxt;
    end
  end

  sys_ctrl_tx_q u_tx_q (
    .i_clk        (CLK),
    .i_rst_n      (RST),
    .i_load       (w_q_load),
    .i_data       (w_q_data),
    .i_two        (w_q_two),
    .i_fifo_full  (FIFO_FULL),
    .o_tx_p_data  (TX_P_DATA),
    .o_tx_d_vld_c (TX_D_VLD),
    .o_done_c     (w_q_done)
  );

endmodule
